// File: rtl/alu_iter_if.sv
// rtl/alu_iter_if.sv - operand/result handshake bundle for the iterative execute-stage ALU
interface alu_iter_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] d_out;
    logic            div_zero;
    logic            illegal_op;
    logic            busy;

    modport master (
        output in_valid, alu_op, src1, src2, out_ready,
        input  in_ready, out_valid, d_out, div_zero, illegal_op, busy
    );

    modport slave (
        input  in_valid, alu_op, src1, src2, out_ready,
        output in_ready, out_valid, d_out, div_zero, illegal_op, busy
    );
endinterface

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - RV32I-style ALU with shift-add multiply and restoring divide
module alu_iter #(
    parameter int XLEN   = 32,
    parameter int MDU_EN = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_iter_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_SLL   = 4'b0010;
    localparam logic [3:0] OP_SLT   = 4'b0011;
    localparam logic [3:0] OP_SLTU  = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_OR    = 4'b1000;
    localparam logic [3:0] OP_AND   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      op_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] hi_q, lo_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] d_out_q;
    logic            div_zero_q, illegal_q;

    logic            accept, is_iter;
    logic [XLEN-1:0] q_res;
    logic            q_dz, q_ill;
    logic [CW-1:0]   shamt;
    logic [XLEN:0]   mul_sum, div_sh;
    logic            div_ge;
    logic [XLEN-1:0] step_hi, step_lo, iter_res;

    assign bus.in_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.busy       = (state_q == S_BUSY);
    assign bus.d_out      = d_out_q;
    assign bus.div_zero   = div_zero_q;
    assign bus.illegal_op = illegal_q;
    assign accept         = bus.in_valid && bus.in_ready;
    assign shamt          = bus.src2[CW-1:0];

    // Single-cycle results, plus the divide-by-zero and illegal short cuts.
    always_comb begin
        q_res   = '0;
        q_dz    = 1'b0;
        q_ill   = 1'b0;
        is_iter = 1'b0;
        case (bus.alu_op)
            OP_ADD:  q_res = bus.src1 + bus.src2;
            OP_SUB:  q_res = bus.src1 - bus.src2;
            OP_SLL:  q_res = bus.src1 << shamt;
            OP_SLT:  q_res = {{(XLEN-1){1'b0}}, ($signed(bus.src1) < $signed(bus.src2))};
            OP_SLTU: q_res = {{(XLEN-1){1'b0}}, (bus.src1 < bus.src2)};
            OP_XOR:  q_res = bus.src1 ^ bus.src2;
            OP_SRL:  q_res = bus.src1 >> shamt;
            OP_SRA:  q_res = $unsigned($signed(bus.src1) >>> shamt);
            OP_OR:   q_res = bus.src1 | bus.src2;
            OP_AND:  q_res = bus.src1 & bus.src2;
            OP_MUL, OP_MULHU: begin
                if (MDU_EN != 0) is_iter = 1'b1;
                else             q_ill   = 1'b1;
            end
            OP_DIVU, OP_REMU: begin
                if (MDU_EN == 0) begin
                    q_ill = 1'b1;
                end else if (bus.src2 == '0) begin
                    q_dz  = 1'b1;
                    q_res = (bus.alu_op == OP_DIVU) ? '1 : bus.src1;
                end else begin
                    is_iter = 1'b1;
                end
            end
            default: q_ill = 1'b1;
        endcase
    end

    // One iteration: {hi,lo} is the product register for MUL*, {remainder,quotient} for DIV.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_ge   = (div_sh >= {1'b0, b_q});
        step_hi  = '0;
        step_lo  = '0;
        iter_res = '0;
        if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end else begin
            step_hi = div_ge ? (div_sh[XLEN-1:0] - b_q) : div_sh[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end
        case (op_q)
            OP_MUL, OP_DIVU: iter_res = step_lo;
            default:         iter_res = step_hi;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = is_iter ? S_BUSY : S_DONE;
            S_BUSY: if (cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE: begin
                if (accept)             state_d = is_iter ? S_BUSY : S_DONE;
                else if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            d_out_q    <= '0;
            div_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (accept) begin
            op_q  <= bus.alu_op;
            b_q   <= bus.src2;
            hi_q  <= '0;
            lo_q  <= bus.src1;
            cnt_q <= '0;
            if (!is_iter) begin
                d_out_q    <= q_res;
                div_zero_q <= q_dz;
                illegal_q  <= q_ill;
            end
        end else if (state_q == S_BUSY) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                d_out_q    <= iter_res;
                div_zero_q <= 1'b0;
                illegal_q  <= 1'b0;
            end
        end
    end
endmodule
